// File: rtl/fp_pkg.sv
// Shared types for the sequential floating-point adder: FSM states, default
// widths, the unpacked operand struct and pack/unpack helpers.
// Combinational helpers only; no latency, no flow control.
package fp_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int FP_WORD_W = FP_EXP_W + FP_MANT_W + 1;
  // Working mantissa is {carry, hidden, frac}.
  localparam int FP_INT_W  = FP_MANT_W + 2;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } fp_state_e;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_INT_W-1:0] mant;
  } fp_op_t;

  // An exponent field of 0 is treated as a signed zero: no hidden bit and the
  // fraction is discarded, since denormals are not supported.
  function automatic fp_op_t fp_unpack(input logic [FP_WORD_W-1:0] w);
    fp_op_t o;
    o.sign = w[FP_WORD_W-1];
    o.exp  = w[FP_WORD_W-2 -: FP_EXP_W];
    o.mant = (o.exp != '0) ? {2'b01, w[FP_MANT_W-1:0]} : '0;
    return o;
  endfunction

  function automatic logic [FP_WORD_W-1:0] fp_pack(input logic                 sign,
                                                   input logic [FP_EXP_W-1:0]  exp,
                                                   input logic [FP_MANT_W-1:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fp_shift_step.sv
// One-bit mantissa shifter with matching exponent step; shared by ALIGN and NORM.
// Latency: purely combinational. Backpressure: none, the caller decides when to load.
// Ports: left_i selects shift-left/exp-1 (else shift-right/exp+1); mant_i/exp_i in,
//        mant_o/exp_o out; ovf_o when a right step lands on an all-ones exponent,
//        unf_o when a left step lands on exponent 0 with the hidden bit still clear.
module fp_shift_step #(
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 25
) (
  input  logic                  left_i,
  input  logic [MANT_WIDTH-1:0] mant_i,
  input  logic [EXP_WIDTH-1:0]  exp_i,
  output logic [MANT_WIDTH-1:0] mant_o,
  output logic [EXP_WIDTH-1:0]  exp_o,
  output logic                  ovf_o,
  output logic                  unf_o
);

  localparam logic [EXP_WIDTH-1:0] EXP_ONE = EXP_WIDTH'(1);

  always_comb begin
    if (left_i) begin
      mant_o = {mant_i[MANT_WIDTH-2:0], 1'b0};
      exp_o  = exp_i - EXP_ONE;
    end else begin
      mant_o = {1'b0, mant_i[MANT_WIDTH-1:1]};
      exp_o  = exp_i + EXP_ONE;
    end
    ovf_o = !left_i && (&exp_o);
    // Hidden bit sits just below the carry bit.
    unf_o = left_i && (exp_o == '0) && !mant_o[MANT_WIDTH-2];
  end

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle FP adder: align, add/sub, normalise one shift per cycle; truncating, no denormals.
// Latency: 3 + d + k cycles from accept to valid_out (d = exp diff capped at MANT+2, k = left shifts).
// Backpressure: one op in flight; ready_out only in IDLE, result and flags held in DONE until ready_in.
// Ports: clk_in, reset_n_in (sync, active low); a_in/b_in/valid_in/ready_out operand side;
//        result_out/valid_out/ready_in/overflow_out/underflow_out result side; busy_out.
// Optional: define FP_ADD_SEQ_PERF_CNT_EN for latency_out, a saturating 8-bit accept-to-valid count.
// Operand widths follow the fp_pkg defaults; the parameters must match them.
module fp_add_sequencer
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH      = FP_EXP_W,
  parameter int MANTISSA_WIDTH = FP_MANT_W
) (
  input  logic                              clk_in,
  input  logic                              reset_n_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] a_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0] b_in,
  input  logic                              valid_in,
  output logic                              ready_out,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0] result_out,
  output logic                              valid_out,
  input  logic                              ready_in,
  output logic                              overflow_out,
  output logic                              underflow_out,
  output logic                              busy_out
`ifdef FP_ADD_SEQ_PERF_CNT_EN
  ,
  output logic [7:0]                        latency_out
`endif
);

  localparam int MW = MANTISSA_WIDTH + 2;
  localparam int CW = $clog2(MW + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MW);

  fp_state_e                         state_q;
  fp_op_t                            a_q, b_q;   // a_q doubles as the working result after ADD
  logic [CW-1:0]                     cnt_q;
  logic [EXP_WIDTH+MANTISSA_WIDTH:0] result_q;
  logic                              valid_q, ovf_q, unf_q, ready_q, busy_q;

  logic                 a_small;
  logic                 sh_left;
  logic [MW-1:0]        sh_mant_in, sh_mant;
  logic [EXP_WIDTH-1:0] sh_exp_in, sh_exp;
  logic                 sh_ovf, sh_unf;

  // ALIGN shifts the smaller-exponent operand right; NORM shifts the working
  // value right on carry, otherwise left.
  always_comb begin
    a_small    = (a_q.exp < b_q.exp);
    sh_left    = (state_q == NORM) && !a_q.mant[MW-1];
    sh_mant_in = a_q.mant;
    sh_exp_in  = a_q.exp;
    if (state_q == ALIGN && !a_small) begin
      sh_mant_in = b_q.mant;
      sh_exp_in  = b_q.exp;
    end
  end

  fp_shift_step #(
    .EXP_WIDTH  (EXP_WIDTH),
    .MANT_WIDTH (MW)
  ) u_shift (
    .left_i (sh_left),
    .mant_i (sh_mant_in),
    .exp_i  (sh_exp_in),
    .mant_o (sh_mant),
    .exp_o  (sh_exp),
    .ovf_o  (sh_ovf),
    .unf_o  (sh_unf)
  );

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_in && ready_q) begin
            a_q     <= fp_unpack(a_in);
            b_q     <= fp_unpack(b_in);
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ALIGN;
          end
        end
        ALIGN: begin
          if (a_q.exp == b_q.exp) begin
            state_q <= ADD;
          end else if (cnt_q == CNT_MAX) begin
            // Every significant bit has been shifted out; snap to the larger exponent.
            if (a_small) begin
              a_q.mant <= '0;
              a_q.exp  <= b_q.exp;
            end else begin
              b_q.mant <= '0;
              b_q.exp  <= a_q.exp;
            end
            state_q <= ADD;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (a_small) begin
              a_q.mant <= sh_mant;
              a_q.exp  <= sh_exp;
            end else begin
              b_q.mant <= sh_mant;
              b_q.exp  <= sh_exp;
            end
          end
        end
        ADD: begin
          if (a_q.sign == b_q.sign) begin
            a_q.mant <= a_q.mant + b_q.mant;
          end else if (a_q.mant > b_q.mant) begin
            a_q.mant <= a_q.mant - b_q.mant;
          end else if (b_q.mant > a_q.mant) begin
            a_q.mant <= b_q.mant - a_q.mant;
            a_q.sign <= b_q.sign;
          end else begin
            a_q.mant <= '0;
            a_q.sign <= 1'b0;
          end
          state_q <= NORM;
        end
        NORM: begin
          if (a_q.mant == '0) begin
            result_q <= '0;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else if (a_q.mant[MW-1]) begin
            if (sh_ovf) begin
              ovf_q    <= 1'b1;
              result_q <= {a_q.sign, {EXP_WIDTH{1'b1}}, {MANTISSA_WIDTH{1'b0}}};
            end else begin
              result_q <= fp_pack(a_q.sign, sh_exp, sh_mant[MANTISSA_WIDTH-1:0]);
            end
            valid_q <= 1'b1;
            state_q <= DONE;
          end else if (a_q.mant[MW-2]) begin
            result_q <= fp_pack(a_q.sign, a_q.exp, a_q.mant[MANTISSA_WIDTH-1:0]);
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else if (sh_unf) begin
            unf_q    <= 1'b1;
            result_q <= '0;
            valid_q  <= 1'b1;
            state_q  <= DONE;
          end else begin
            a_q.mant <= sh_mant;
            a_q.exp  <= sh_exp;
          end
        end
        DONE: begin
          if (ready_in) begin
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_out     = ready_q;
  assign busy_out      = busy_q;
  assign valid_out     = valid_q;
  assign result_out    = result_q;
  assign overflow_out  = ovf_q;
  assign underflow_out = unf_q;

`ifdef FP_ADD_SEQ_PERF_CNT_EN
  // Each ALIGN/ADD/NORM cycle is one cycle of accept-to-valid latency.
  logic [7:0] lat_q;

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      lat_q <= '0;
    end else if (state_q == IDLE && valid_in && ready_q) begin
      lat_q <= '0;
    end else if ((state_q inside {ALIGN, ADD, NORM}) && lat_q != 8'hFF) begin
      lat_q <= lat_q + 8'd1;
    end
  end

  assign latency_out = lat_q;
`endif

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Self-checking bench for fp_add_sequencer: directed vectors, randomized
// operands against an arithmetic reference, backpressure and mid-op reset.
module tb_fp_add_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] a, b;
  logic        valid_in, ready_in;
  logic        ready_out, valid_out, overflow_out, underflow_out, busy_out;
  logic [31:0] result_out;
`ifdef FP_ADD_SEQ_PERF_CNT_EN
  logic [7:0]  latency;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fp_add_sequencer dut (
    .clk_in        (clk),
    .reset_n_in    (reset_n),
    .a_in          (a),
    .b_in          (b),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .result_out    (result_out),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .overflow_out  (overflow_out),
    .underflow_out (underflow_out),
    .busy_out      (busy_out)
`ifdef FP_ADD_SEQ_PERF_CNT_EN
    ,
    .latency_out   (latency)
`endif
  );

  // Reference: align by a single right shift of d bits (everything lost past
  // the working width), signed add, then normalise with truncation.
  function automatic void ref_add(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic ovf,
                                  output logic unf, output int lat);
    int     ex, ey, e, d, k, ne;
    longint mx, my, m, nm;
    logic   s;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = (ex != 0) ? longint'({1'b1, x[22:0]}) : 0;
    my = (ey != 0) ? longint'({1'b1, y[22:0]}) : 0;
    d  = (ex > ey) ? ex - ey : ey - ex;
    if (ex < ey)      mx = (d >= 25) ? 0 : (mx >> d);
    else if (ey < ex) my = (d >= 25) ? 0 : (my >> d);
    e   = (ex > ey) ? ex : ey;
    lat = 3 + ((d > 25) ? 25 : d);
    if (x[31] == y[31]) begin m = mx + my; s = x[31]; end
    else if (mx > my)   begin m = mx - my; s = x[31]; end
    else if (my > mx)   begin m = my - mx; s = y[31]; end
    else                begin m = 0;       s = 1'b0;  end
    ovf = 1'b0; unf = 1'b0; k = 0;
    if (m == 0) begin
      r = 32'h0;
    end else if (m >= (64'd1 << 24)) begin
      m = m >> 1;
      e = (e + 1) % 256;
      if (e == 255) begin ovf = 1'b1; r = {s, 8'hFF, 23'd0}; end
      else          r = {s, e[7:0], m[22:0]};
    end else begin
      while (m < (64'd1 << 23) && !unf) begin
        nm = m << 1;
        ne = e - 1;
        if (ne == 0 && nm < (64'd1 << 23)) unf = 1'b1;
        else begin m = nm; e = ne; k++; end
      end
      r = unf ? 32'h0 : {s, e[7:0], m[22:0]};
    end
    lat = lat + k;
  endfunction

  // All helpers run from posedge+1; inputs change there, outputs are sampled there.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 200) begin
      if (ready_out) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      n++;
    end
    if (ok) begin
      a = x; b = y; valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
    end
  endtask

  task automatic wait_result(output logic [31:0] r, output logic o, output logic u,
                             output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    while (lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (valid_out) begin ok = 1'b1; break; end
    end
    r = result_out; o = overflow_out; u = underflow_out;
  endtask

  task automatic ack();
    ready_in = 1'b1;
    @(posedge clk); #1;
    ready_in = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({ready_out, valid_out, busy_out, overflow_out, underflow_out} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_ctrl got r/v/b/o/u=%b expected 10000",
               {ready_out, valid_out, busy_out, overflow_out, underflow_out});
    end
    tests_run++;
    if (result_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_result got %h expected 00000000", result_out);
    end
  endtask

  task automatic test_directed();
    logic [31:0] da [8] = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h7F7FFFFF,
                            32'h3F800001, 32'h00800001, 32'h4B800000, 32'h50000000};
    logic [31:0] db [8] = '{32'h3F800000, 32'h3F000000, 32'hBF800000, 32'h7F7FFFFF,
                            32'hBF800000, 32'h80800000, 32'h3F800000, 32'h3F800000};
    logic [31:0] dr [8] = '{32'h40000000, 32'h40600000, 32'h00000000, 32'h7F800000,
                            32'h34000000, 32'h00000000, 32'h4B800000, 32'h50000000};
    logic [1:0]  dfl[8] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00};
    int          dl [8] = '{3, 5, 3, 3, 26, 3, 27, 28};
    logic [31:0] r; logic o, u; int lat; bit ok;
    for (int i = 0; i < 8; i++) begin
      start_op(da[i], db[i], ok);
      if (ok) wait_result(r, o, u, lat, ok);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL directed_timeout vec=%0d got no result expected valid_out", i);
        continue;
      end
      tests_run++;
      if (r !== dr[i]) begin
        tests_failed++;
        $display("FAIL directed_result vec=%0d got %h expected %h", i, r, dr[i]);
      end
      tests_run++;
      if ({o, u} !== dfl[i]) begin
        tests_failed++;
        $display("FAIL directed_flags vec=%0d got ovf/unf=%b expected %b", i, {o, u}, dfl[i]);
      end
      tests_run++;
      if (lat != dl[i]) begin
        tests_failed++;
        $display("FAIL directed_latency vec=%0d got %0d expected %0d", i, lat, dl[i]);
      end
`ifdef FP_ADD_SEQ_PERF_CNT_EN
      tests_run++;
      if (latency !== 8'(dl[i])) begin
        tests_failed++;
        $display("FAIL perf_counter vec=%0d got %0d expected %0d", i, latency, dl[i]);
      end
`endif
      ack();
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, r, er; logic o, u, eo, eu; int lat, el; bit ok;
    int ea, eb;
    for (int i = 0; i < 200; i++) begin
      ea = $urandom_range(60, 190);
      eb = ($urandom_range(0, 9) == 0) ? 0 : ea + $urandom_range(0, 40) - 20;
      x  = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
      y  = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
      // Near-cancellation exercises long left normalisation.
      if ($urandom_range(0, 3) == 0) y = {~x[31], x[30:23], x[22:0] ^ 23'($urandom_range(0, 255))};
      ref_add(x, y, er, eo, eu, el);
      start_op(x, y, ok);
      if (ok) wait_result(r, o, u, lat, ok);
      tests_run++;
      if (!ok || r !== er || {o, u} !== {eo, eu} || lat != el) begin
        tests_failed++;
        $display("FAIL random op=%0d a=%h b=%h got res=%h ovf/unf=%b lat=%0d expected res=%h ovf/unf=%b lat=%0d",
                 i, x, y, r, {o, u}, lat, er, {eo, eu}, el);
      end
      if (ok) ack();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] r, er; logic o, u, eo, eu; int lat, el; bit ok;
    ref_add(32'h40400000, 32'h3F000000, er, eo, eu, el);
    start_op(32'h40400000, 32'h3F000000, ok);
    if (ok) wait_result(r, o, u, lat, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL backpressure_timeout got no result expected valid_out");
      return;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if ({valid_out, ready_out, busy_out} !== 3'b101 || result_out !== er ||
          {overflow_out, underflow_out} !== {eo, eu}) begin
        tests_failed++;
        $display("FAIL backpressure_hold cycle=%0d got v/r/b=%b res=%h flags=%b expected 101 res=%h flags=%b",
                 i, {valid_out, ready_out, busy_out}, result_out, {overflow_out, underflow_out},
                 er, {eo, eu});
      end
    end
    ack();
    tests_run++;
    if ({valid_out, ready_out, busy_out} !== 3'b010) begin
      tests_failed++;
      $display("FAIL backpressure_release got v/r/b=%b expected 010", {valid_out, ready_out, busy_out});
    end
  endtask

  task automatic test_reset_mid_align();
    logic [31:0] r; logic o, u; int lat; bit ok;
    bit saw_valid;
    start_op(32'h4B000000, 32'h3F800000, ok);   // d = 23, long ALIGN phase
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({valid_out, ready_out, busy_out} !== 3'b010) begin
      tests_failed++;
      $display("FAIL reset_mid_align got v/r/b=%b expected 010", {valid_out, ready_out, busy_out});
    end
    reset_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (valid_out) saw_valid = 1'b1;
    end
    tests_run++;
    if (saw_valid) begin
      tests_failed++;
      $display("FAIL reset_abandon got valid_out=1 expected no output after reset");
    end
    start_op(32'h3F800000, 32'h3F800000, ok);
    if (ok) wait_result(r, o, u, lat, ok);
    tests_run++;
    if (!ok || r !== 32'h40000000 || lat != 3) begin
      tests_failed++;
      $display("FAIL reset_recover got ok=%0d res=%h lat=%0d expected res=40000000 lat=3", ok, r, lat);
    end
    if (ok) ack();
  endtask

  initial begin
    reset_n  = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    a        = '0;
    b        = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_align();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
